uart_rx_cfg: RTL

//  Parametrised UART receiver for 8N1-style serial links. Synchronises RX, hunts
//  for a start bit, then samples each bit at its mid-point. Presents an LSB-first

---
 rtl/uart_rx_cfg.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with error flags; optional parity via UART_RX_PARITY_EN
module uart_rx_cfg #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 2604,
    parameter int SYNC_STAGES  = 2,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    input  logic                 clr_rx_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_rdy,
    output logic                 frm_err,
    output logic                 ovr_err,
    output logic                 par_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic [CW-1:0]          cnt;
    logic [3:0]             bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   half_tick, full_tick;
    logic                   shift_en, stop_done;

    assign rx_s = sync[SYNC_STAGES-1];

    // Metastability synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clk) begin
        if (rst) sync <= '1;
        else     sync <= {sync[SYNC_STAGES-2:0], RX};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and sample strobes
    always_comb begin
        state_nxt = state;
        half_tick = (cnt == CNT_HALF);
        full_tick = (cnt == CNT_FULL);
        shift_en  = 1'b0;
        stop_done = 1'b0;
        case (state)
            IDLE:  if (!rx_s) state_nxt = START;
            START: if (half_tick) state_nxt = rx_s ? IDLE : DATA;
            DATA: begin
                if (full_tick) begin
                    shift_en = 1'b1;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (full_tick) state_nxt = STOP;
`endif
            STOP: begin
                if (full_tick) begin
                    stop_done = 1'b1;
                    state_nxt = rx_s ? IDLE : BREAK;
                end
            end
            BREAK:   if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Baud counter restarts on every state change and after each data sample
    always_ff @(posedge clk) begin
        if (rst || state_nxt != state || shift_en || state == IDLE || state == BREAK)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Bit index and LSB-first shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state == START)  bit_idx <= '0;
            else if (shift_en)   bit_idx <= bit_idx + 1'b1;
            if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
        end
    end

    // Word delivery, ready handshake and error flags; a completing frame beats clr_rx_rdy
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data <= '0;
            rx_rdy  <= 1'b0;
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
        end else if (stop_done) begin
            rx_data <= shreg;
            rx_rdy  <= 1'b1;
            frm_err <= ~rx_s;
            if (rx_rdy && !clr_rx_rdy) ovr_err <= 1'b1;
            else if (clr_rx_rdy)       ovr_err <= 1'b0;
        end else if (clr_rx_rdy) begin
            rx_rdy  <= 1'b0;
            ovr_err <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    // Capture the parity bit, then judge the whole frame at the stop sample
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit <= 1'b0;
            par_err <= 1'b0;
        end else begin
            if (state == PARITY && full_tick) par_bit <= rx_s;
            if (stop_done) par_err <= ((^shreg) ^ par_bit) != PARITY_ODD[0];
        end
    end
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = PARITY_ODD[0];
    assign par_err = 1'b0;
`endif

endmodule
